centroid_tracker: RTL and testbench

- Upstream feeder for the camera-control stage.
- Accumulates the pixel count and the x/y coordinate sums of mask-selected pixels over one video frame.
- At end of frame, divides the sums by the count using serial dividers.
- Emits a one-cycle-valid (x, y, area) tuple that drives the camera-control x/y/area/valid inputs.

---
 rtl/cam_pkg.sv | 28 ++
 rtl/centroid_tracker_if.sv | 32 +++
 rtl/serial_divider.sv | 67 ++++++
 rtl/centroid_tracker.sv | 156 +++++++++++++++
 tb/tb_centroid_tracker.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/cam_pkg.sv
// Shared definitions for the camera pipeline: tracker FSM states, default
// frame geometry and the width helpers used to size coordinate/area buses.
package cam_pkg;

  localparam int unsigned HRES_DEFAULT = 320;
  localparam int unsigned VRES_DEFAULT = 180;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    OUT
  } tracker_state_t;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int unsigned coord_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the selected-pixel count for an h x v frame.
  function automatic int unsigned area_width(input int unsigned h, input int unsigned v);
    return coord_width(h * v);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/centroid_tracker_if.sv
// Pixel-stream inputs and centroid result outputs of the tracker.
interface centroid_tracker_if #(
  parameter int unsigned HWIDTH = cam_pkg::coord_width(cam_pkg::HRES_DEFAULT),
  parameter int unsigned VWIDTH = cam_pkg::coord_width(cam_pkg::VRES_DEFAULT),
  parameter int unsigned AWIDTH = cam_pkg::area_width(cam_pkg::HRES_DEFAULT,
                                                      cam_pkg::VRES_DEFAULT)
) ();

  logic [HWIDTH-1:0] hcount_in;
  logic [VWIDTH-1:0] vcount_in;
  logic              mask_in;
  logic              pixel_valid_in;
  logic              frame_done_in;
  logic [HWIDTH-1:0] x_out;
  logic [VWIDTH-1:0] y_out;
  logic [AWIDTH-1:0] area_out;
  logic              valid_out;
  logic              busy_out;

  // Pixel source side.
  modport master (
    output hcount_in, vcount_in, mask_in, pixel_valid_in, frame_done_in,
    input  x_out, y_out, area_out, valid_out, busy_out
  );

  // Tracker side.
  modport slave (
    input  hcount_in, vcount_in, mask_in, pixel_valid_in, frame_done_in,
    output x_out, y_out, area_out, valid_out, busy_out
  );

endinterface

// File: rtl/serial_divider.sv
// Restoring divider, one quotient bit per cycle, QUOT_W cycles per division.
// The caller guarantees dividend < divisor * 2^QUOT_W so the quotient fits.
module serial_divider
  import cam_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = 25,
  parameter int unsigned DIVISOR_W  = 16,
  parameter int unsigned QUOT_W     = 9
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [QUOT_W-1:0]     quotient
);

  localparam int unsigned REM_W = max_u(DIVIDEND_W, DIVISOR_W + QUOT_W);
  localparam int unsigned CNT_W = coord_width(QUOT_W);

  logic [REM_W-1:0]  rem_q;
  logic [REM_W-1:0]  den_q;
  logic [QUOT_W-1:0] quot_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              take;

  // Current trial subtraction succeeds when the shifted divisor fits.
  always_comb begin
    take = (rem_q >= den_q);
  end

  // Load on start, then shift the divisor down one bit per iteration.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rem_q  <= '0;
      den_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= REM_W'(dividend);
      den_q  <= REM_W'(divisor) << (QUOT_W - 1);
      quot_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (take) begin
        rem_q <= rem_q - den_q;
      end
      quot_q <= (quot_q << 1) | QUOT_W'(take);
      den_q  <= den_q >> 1;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(QUOT_W - 1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy     = busy_q;
  // High during the cycle whose edge produces the last quotient bit.
  assign done     = busy_q && (cnt_q == CNT_W'(QUOT_W - 1));
  assign quotient = quot_q;

endmodule

// File: rtl/centroid_tracker.sv
// Accumulates mask-selected pixel count and coordinate sums over a frame, then
// divides them at end of frame to produce a one-cycle-valid centroid result.
module centroid_tracker
  import cam_pkg::*;
#(
  parameter int unsigned HRES     = HRES_DEFAULT,
  parameter int unsigned VRES     = VRES_DEFAULT,
  parameter int unsigned MIN_AREA = 1
) (
  input logic               clk_in,
  input logic               rst_in,
  centroid_tracker_if.slave bus
);

  localparam int unsigned HWIDTH = coord_width(HRES);
  localparam int unsigned VWIDTH = coord_width(VRES);
  localparam int unsigned AWIDTH = area_width(HRES, VRES);
  localparam int unsigned SXW    = HWIDTH + AWIDTH;
  localparam int unsigned SYW    = VWIDTH + AWIDTH;

  logic              sel;
  logic [AWIDTH-1:0] count_q, count_next;
  logic [SXW-1:0]    sum_x_q, sum_x_next;
  logic [SYW-1:0]    sum_y_q, sum_y_next;
  logic              area_ok;
  logic              start_div;

  logic              x_busy, x_done, y_busy, y_done;
  logic [HWIDTH-1:0] x_quot;
  logic [VWIDTH-1:0] y_quot;

  tracker_state_t    state_q;
  logic              x_fin_q, y_fin_q;
  logic [AWIDTH-1:0] area_snap_q;
  logic [HWIDTH-1:0] x_q;
  logic [VWIDTH-1:0] y_q;
  logic [AWIDTH-1:0] area_q;
  logic              valid_q, busy_q;

  // Totals including this cycle's pixel, so a pixel coincident with
  // frame_done_in still lands in the ending frame's snapshot.
  always_comb begin
    sel        = bus.pixel_valid_in & bus.mask_in;
    count_next = count_q;
    sum_x_next = sum_x_q;
    sum_y_next = sum_y_q;
    if (sel) begin
      if (count_q != '1) begin
        count_next = count_q + AWIDTH'(1);
      end
      sum_x_next = sum_x_q + SXW'(bus.hcount_in);
      sum_y_next = sum_y_q + SYW'(bus.vcount_in);
    end
    area_ok   = (32'(count_next) >= MIN_AREA);
    start_div = (state_q == IDLE) && bus.frame_done_in && area_ok && !x_busy && !y_busy;
  end

  // Accumulators run regardless of FSM state and restart at each frame end.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count_q <= '0;
      sum_x_q <= '0;
      sum_y_q <= '0;
    end else if (bus.frame_done_in) begin
      count_q <= '0;
      sum_x_q <= '0;
      sum_y_q <= '0;
    end else begin
      count_q <= count_next;
      sum_x_q <= sum_x_next;
      sum_y_q <= sum_y_next;
    end
  end

  serial_divider #(
    .DIVIDEND_W (SXW),
    .DIVISOR_W  (AWIDTH),
    .QUOT_W     (HWIDTH)
  ) u_div_x (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (start_div),
    .dividend (sum_x_next),
    .divisor  (count_next),
    .busy     (x_busy),
    .done     (x_done),
    .quotient (x_quot)
  );

  serial_divider #(
    .DIVIDEND_W (SYW),
    .DIVISOR_W  (AWIDTH),
    .QUOT_W     (VWIDTH)
  ) u_div_y (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .start    (start_div),
    .dividend (sum_y_next),
    .divisor  (count_next),
    .busy     (y_busy),
    .done     (y_done),
    .quotient (y_quot)
  );

  // Control FSM with registered outputs; DIV lasts until both dividers have
  // finished, i.e. max(HWIDTH, VWIDTH) cycles.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= IDLE;
      x_fin_q     <= 1'b0;
      y_fin_q     <= 1'b0;
      area_snap_q <= '0;
      x_q         <= '0;
      y_q         <= '0;
      area_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_div) begin
            state_q     <= DIV;
            busy_q      <= 1'b1;
            area_snap_q <= count_next;
            x_fin_q     <= 1'b0;
            y_fin_q     <= 1'b0;
          end
        end
        DIV: begin
          x_fin_q <= x_fin_q | x_done;
          y_fin_q <= y_fin_q | y_done;
          if ((x_fin_q | x_done) && (y_fin_q | y_done)) begin
            state_q <= OUT;
            busy_q  <= 1'b0;
          end
        end
        OUT: begin
          x_q     <= x_quot;
          y_q     <= y_quot;
          area_q  <= area_snap_q;
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.x_out     = x_q;
  assign bus.y_out     = y_q;
  assign bus.area_out  = area_q;
  assign bus.valid_out = valid_q;
  assign bus.busy_out  = busy_q;

endmodule

// File: tb/tb_centroid_tracker.sv
// Directed bench for centroid_tracker at default geometry (320x180).
module tb_centroid_tracker;

  localparam int HW = 9;
  localparam int VW = 8;
  localparam int AW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   passed = 0;
  int   vcnt   = 0;

  always #5 clk = ~clk;

  centroid_tracker_if #(.HWIDTH(HW), .VWIDTH(VW), .AWIDTH(AW)) bus ();

  centroid_tracker #(.HRES(320), .VRES(180), .MIN_AREA(1)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  // Count valid pulses, sampled away from the active edge.
  always @(negedge clk) if (bus.valid_out === 1'b1) vcnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input int h, input int v);
    bus.pixel_valid_in = 1'b1;
    bus.mask_in        = 1'b1;
    bus.hcount_in      = HW'(h);
    bus.vcount_in      = VW'(v);
    tick();
    bus.pixel_valid_in = 1'b0;
    bus.mask_in        = 1'b0;
  endtask

  task automatic frame_end(input bit with_pix, input int h, input int v);
    bus.frame_done_in  = 1'b1;
    bus.pixel_valid_in = with_pix;
    bus.mask_in        = with_pix;
    bus.hcount_in      = HW'(h);
    bus.vcount_in      = VW'(v);
    tick();
    bus.frame_done_in  = 1'b0;
    bus.pixel_valid_in = 1'b0;
    bus.mask_in        = 1'b0;
  endtask

  // Called one sample after frame_done; returns ticks until valid_out (bounded).
  task automatic wait_valid(output int n);
    n = 0;
    while (bus.valid_out !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    checks++; if (bus.x_out !== 9'd0) $display("FAIL reset_x got %0d want 0", bus.x_out); else passed++;
    checks++; if (bus.y_out !== 8'd0) $display("FAIL reset_y got %0d want 0", bus.y_out); else passed++;
    checks++; if (bus.area_out !== 16'd0) $display("FAIL reset_area got %0d want 0", bus.area_out); else passed++;
    checks++; if (bus.valid_out !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.valid_out); else passed++;
    checks++; if (bus.busy_out !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy_out); else passed++;
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n;
    send_pixel(100, 50);
    frame_end(1'b0, 0, 0);
    checks++; if (bus.busy_out !== 1'b1) $display("FAIL single_busy got %b want 1", bus.busy_out); else passed++;
    wait_valid(n);
    checks++; if (n !== 10) $display("FAIL single_latency got %0d want 10", n); else passed++;
    checks++; if (bus.x_out !== 9'd100) $display("FAIL single_x got %0d want 100", bus.x_out); else passed++;
    checks++; if (bus.y_out !== 8'd50) $display("FAIL single_y got %0d want 50", bus.y_out); else passed++;
    checks++; if (bus.area_out !== 16'd1) $display("FAIL single_area got %0d want 1", bus.area_out); else passed++;
    tick();
    checks++; if (bus.valid_out !== 1'b0) $display("FAIL single_pulse_width got %b want 0", bus.valid_out); else passed++;
  endtask

  task automatic test_block();
    int n;
    int busy_cnt;
    for (int v = 20; v < 30; v++)
      for (int h = 10; h < 20; h++) send_pixel(h, v);
    frame_end(1'b0, 0, 0);
    busy_cnt = (bus.busy_out === 1'b1) ? 1 : 0;
    n = 0;
    while (bus.valid_out !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (bus.busy_out === 1'b1) busy_cnt++;
    end
    checks++; if (n !== 10) $display("FAIL block_latency got %0d want 10", n); else passed++;
    checks++; if (busy_cnt !== 9) $display("FAIL block_busy_cycles got %0d want 9", busy_cnt); else passed++;
    checks++; if (bus.x_out !== 9'd14) $display("FAIL block_x got %0d want 14", bus.x_out); else passed++;
    checks++; if (bus.y_out !== 8'd24) $display("FAIL block_y got %0d want 24", bus.y_out); else passed++;
    checks++; if (bus.area_out !== 16'd100) $display("FAIL block_area got %0d want 100", bus.area_out); else passed++;
  endtask

  task automatic test_full_frame();
    int n;
    int v0;
    for (int v = 0; v < 180; v++)
      for (int h = 0; h < 320; h++) send_pixel(h, v);
    frame_end(1'b0, 0, 0);
    wait_valid(n);
    checks++; if (n !== 10) $display("FAIL full_latency got %0d want 10", n); else passed++;
    checks++; if (bus.x_out !== 9'd159) $display("FAIL full_x got %0d want 159", bus.x_out); else passed++;
    checks++; if (bus.y_out !== 8'd89) $display("FAIL full_y got %0d want 89", bus.y_out); else passed++;
    checks++; if (bus.area_out !== 16'd57600) $display("FAIL full_area got %0d want 57600", bus.area_out); else passed++;
    // Empty frame: no pulse, outputs hold.
    tick();
    v0 = vcnt;
    frame_end(1'b0, 0, 0);
    repeat (20) tick();
    checks++; if (vcnt !== v0) $display("FAIL empty_pulses got %0d want %0d", vcnt, v0); else passed++;
    checks++; if (bus.busy_out !== 1'b0) $display("FAIL empty_busy got %b want 0", bus.busy_out); else passed++;
    checks++; if (bus.x_out !== 9'd159) $display("FAIL empty_x_hold got %0d want 159", bus.x_out); else passed++;
    checks++; if (bus.y_out !== 8'd89) $display("FAIL empty_y_hold got %0d want 89", bus.y_out); else passed++;
    checks++; if (bus.area_out !== 16'd57600) $display("FAIL empty_area_hold got %0d want 57600", bus.area_out); else passed++;
  endtask

  task automatic test_same_cycle();
    int n;
    frame_end(1'b1, 319, 179);
    wait_valid(n);
    checks++; if (n !== 10) $display("FAIL corner_latency got %0d want 10", n); else passed++;
    checks++; if (bus.x_out !== 9'd319) $display("FAIL corner_x got %0d want 319", bus.x_out); else passed++;
    checks++; if (bus.y_out !== 8'd179) $display("FAIL corner_y got %0d want 179", bus.y_out); else passed++;
    checks++; if (bus.area_out !== 16'd1) $display("FAIL corner_area got %0d want 1", bus.area_out); else passed++;
    tick();
    send_pixel(0, 0);
    frame_end(1'b0, 0, 0);
    wait_valid(n);
    checks++; if (bus.x_out !== 9'd0) $display("FAIL origin_x got %0d want 0", bus.x_out); else passed++;
    checks++; if (bus.y_out !== 8'd0) $display("FAIL origin_y got %0d want 0", bus.y_out); else passed++;
    checks++; if (bus.area_out !== 16'd1) $display("FAIL origin_area got %0d want 1", bus.area_out); else passed++;
  endtask

  task automatic test_back_to_back();
    int v0;
    tick();
    v0 = vcnt;
    send_pixel(5, 5);
    frame_end(1'b0, 0, 0);  // pulse in cycle T
    send_pixel(7, 7);       // T+1
    tick();                 // T+2
    frame_end(1'b0, 0, 0);  // pulse in cycle T+3, lands in DIV
    repeat (30) tick();
    checks++; if (vcnt - v0 !== 1) $display("FAIL b2b_pulses got %0d want 1", vcnt - v0); else passed++;
    checks++; if (bus.x_out !== 9'd5) $display("FAIL b2b_x got %0d want 5", bus.x_out); else passed++;
    checks++; if (bus.y_out !== 8'd5) $display("FAIL b2b_y got %0d want 5", bus.y_out); else passed++;
    checks++; if (bus.area_out !== 16'd1) $display("FAIL b2b_area got %0d want 1", bus.area_out); else passed++;
  endtask

  task automatic test_reset_mid_div();
    int n;
    int v0;
    send_pixel(100, 50);
    frame_end(1'b0, 0, 0);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.x_out !== 9'd0) $display("FAIL rst_mid_x got %0d want 0", bus.x_out); else passed++;
    checks++; if (bus.y_out !== 8'd0) $display("FAIL rst_mid_y got %0d want 0", bus.y_out); else passed++;
    checks++; if (bus.area_out !== 16'd0) $display("FAIL rst_mid_area got %0d want 0", bus.area_out); else passed++;
    checks++; if (bus.busy_out !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", bus.busy_out); else passed++;
    checks++; if (bus.valid_out !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", bus.valid_out); else passed++;
    v0 = vcnt;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) tick();
    checks++; if (vcnt !== v0) $display("FAIL rst_after_pulses got %0d want %0d", vcnt, v0); else passed++;
    checks++; if (bus.x_out !== 9'd0) $display("FAIL rst_after_x got %0d want 0", bus.x_out); else passed++;
    send_pixel(30, 40);
    send_pixel(32, 44);
    frame_end(1'b0, 0, 0);
    wait_valid(n);
    checks++; if (n !== 10) $display("FAIL post_rst_latency got %0d want 10", n); else passed++;
    checks++; if (bus.x_out !== 9'd31) $display("FAIL post_rst_x got %0d want 31", bus.x_out); else passed++;
    checks++; if (bus.y_out !== 8'd42) $display("FAIL post_rst_y got %0d want 42", bus.y_out); else passed++;
    checks++; if (bus.area_out !== 16'd2) $display("FAIL post_rst_area got %0d want 2", bus.area_out); else passed++;
  endtask

  initial begin
    bus.hcount_in      = '0;
    bus.vcount_in      = '0;
    bus.mask_in        = 1'b0;
    bus.pixel_valid_in = 1'b0;
    bus.frame_done_in  = 1'b0;
    test_reset();
    test_single();
    test_block();
    test_full_frame();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
